rr_seq_unit: RTL and testbench

Sequential rotate-right unit for the ALU datapath, the inverse direction of the existing rotate-left slice. It accepts an operand, an opcode and a rotate amount on a start strobe, then rotates the registered result right one bit per clock until done. Result, busy and done are registered. It sits beside the other ALU function slices and is selected by the same 4-bit opcode field.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/rotr_step.sv | 11 +
 rtl/rr_seq_unit.sv | 113 +++++++++++
 tb/tb_rr_seq_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: the opcode encodings that select each function slice
// and the state type for the sequential rotate-right slice.
package alu_pkg;

   // Opcode encodings on the shared 4-bit ALU function-select field
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_RR_A = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_RL   = 4'b0110;
   localparam logic [3:0] OP_RR_B = 4'b1000;

   // Rotate-right sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } rr_state_t;

endpackage

// File: rtl/rotr_step.sv
// One-position circular right rotation; the LSB wraps into the MSB.
module rotr_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   assign out = {in[0], in[WIDTH-1:1]};

endmodule

// File: rtl/rr_seq_unit.sv
// Sequential rotate-right ALU slice: captures an operand on start and rotates
// the registered result right by one bit per clock until the requested amount
// (modulo WIDTH) has been applied, then pulses done for one cycle.
module rr_seq_unit
   import alu_pkg::*;
#(
   parameter int         WIDTH   = 4,
   parameter int         AMT_W   = 3,
   parameter logic [3:0] OP_RR_A = alu_pkg::OP_RR_A,
   parameter logic [3:0] OP_RR_B = alu_pkg::OP_RR_B
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             start,
   input  logic [WIDTH-1:0] q,
   input  logic [3:0]       s,
   input  logic [AMT_W-1:0] amt,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done
);

   localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
   localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

   // Amount reduced modulo WIDTH; done in 32 bits so WIDTH need not fit in AMT_W.
   function automatic logic [AMT_W-1:0] amt_mod(input logic [AMT_W-1:0] a);
      logic [31:0] wide;
      wide = {{(32-AMT_W){1'b0}}, a} % 32'(WIDTH);
      return wide[AMT_W-1:0];
   endfunction

   rr_state_t        state;
   rr_state_t        next_state;
   logic [AMT_W-1:0] cnt;
   logic [AMT_W-1:0] next_cnt;
   logic [WIDTH-1:0] next_r;
   logic [WIDTH-1:0] rot;
   logic             rr_sel;

   assign rr_sel = (s == OP_RR_A) || (s == OP_RR_B);

   rotr_step #(
      .WIDTH (WIDTH)
   ) u_rotr_step (
      .in  (r),
      .out (rot)
   );

   // Next-state, next-result and next-count decode for the sequencer
   always_comb begin
      next_state = state;
      next_r     = r;
      next_cnt   = cnt;
      case (state)
         IDLE: begin
            if (start) begin
               if (rr_sel) begin
                  next_r   = q;
                  next_cnt = amt_mod(amt);
               end else begin
                  // Unselected opcode behaves like any idle ALU slice: zero result.
                  next_r   = {WIDTH{1'b0}};
                  next_cnt = CNT_ZERO;
               end
               if (next_cnt == CNT_ZERO) begin
                  next_state = DONE;
               end else begin
                  next_state = SHIFT;
               end
            end else begin
               next_state = IDLE;
            end
         end
         SHIFT: begin
            next_r   = rot;
            next_cnt = cnt - CNT_ONE;
            // cnt==0 cannot occur in SHIFT; treat it as finished rather than wrap.
            if ((cnt == CNT_ONE) || (cnt == CNT_ZERO)) begin
               next_state = DONE;
            end else begin
               next_state = SHIFT;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
            next_r     = {WIDTH{1'b0}};
            next_cnt   = CNT_ZERO;
         end
      endcase
   end

   // State, result, counter and status flags; busy/done follow the next state
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
         r     <= {WIDTH{1'b0}};
         cnt   <= CNT_ZERO;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= next_state;
         r     <= next_r;
         cnt   <= next_cnt;
         busy  <= (next_state == SHIFT);
         done  <= (next_state == DONE);
      end
   end

endmodule

// File: tb/tb_rr_seq_unit.sv
// Scoreboard bench for rr_seq_unit: stimulus pushes the expected final result
// and done cycle; an independent monitor pops and compares on every done pulse.
module tb_rr_seq_unit;

   logic       clk;
   logic       Reset;
   logic       start;
   logic [3:0] q;
   logic [3:0] s;
   logic [2:0] amt;
   logic [3:0] r;
   logic       busy;
   logic       done;

   typedef struct {
      string      name;
      logic [3:0] r;
      int         cyc;
      int         k;
   } exp_t;

   exp_t sbq[$];
   int   n_vec    = 0;
   int   n_err    = 0;
   int   cyc      = 0;
   int   busy_cnt = 0;

   rr_seq_unit #(
      .WIDTH   (4),
      .AMT_W   (3),
      .OP_RR_A (4'b0100),
      .OP_RR_B (4'b1000)
   ) dut (
      .clk   (clk),
      .Reset (Reset),
      .start (start),
      .q     (q),
      .s     (s),
      .amt   (amt),
      .r     (r),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   // Monitor: checks result, done timing and busy length on every done pulse
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!Reset) begin
         busy_cnt = 0;
      end else begin
         if (busy && done) begin
            n_vec++;
            n_err++;
            $display("FAIL busy_done_overlap: got busy=1 done=1 expected exclusive");
         end
         if (busy) busy_cnt++;
         if (done) begin
            if (sbq.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_done: got done with r=%b expected no done", r);
            end else begin
               e = sbq.pop_front();
               chk({e.name, "_r"}, r, e.r);
               n_vec++;
               if (cyc != e.cyc) begin
                  n_err++;
                  $display("FAIL %s_latency: got cycle %0d expected cycle %0d", e.name, cyc, e.cyc);
               end
               n_vec++;
               if (busy_cnt != e.k) begin
                  n_err++;
                  $display("FAIL %s_busy: got %0d busy cycles expected %0d", e.name, busy_cnt, e.k);
               end
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic wait_idle(input string nm);
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (sbq.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_timeout: got %0d pending results expected 0", nm, sbq.size());
         sbq.delete();
      end
      @(negedge clk);
   endtask

   task automatic scramble();
      q   = 4'($urandom);
      s   = 4'($urandom);
      amt = 3'($urandom);
   endtask

   task automatic issue(input string nm, input logic [3:0] qv, input logic [3:0] sv,
                        input logic [2:0] av, input logic [3:0] er, input int k);
      @(negedge clk);
      q     = qv;
      s     = sv;
      amt   = av;
      start = 1'b1;
      sbq.push_back('{nm, er, cyc + 1 + k, k});
      @(negedge clk);
      start = 1'b0;
      scramble();
      wait_idle(nm);
   endtask

   initial begin
      int n0;
      Reset = 1'b0;
      start = 1'b0;
      scramble();

      // Reset held with random inputs, including start
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         scramble();
         start = 1'b1;
         chk("rst_r", r, 4'b0000);
         chk("rst_busy", {3'b000, busy}, 4'b0000);
         chk("rst_done", {3'b000, done}, 4'b0000);
      end
      start = 1'b0;
      Reset = 1'b1;
      @(negedge clk);

      // Directed vectors: name, q, s, amt, final r, steps
      issue("rr_a_amt1",  4'b1001, 4'b0100, 3'd1, 4'b1100, 1);
      issue("rr_b_amt5",  4'b1001, 4'b1000, 3'd5, 4'b1100, 1);
      issue("rr_amt0",    4'b1011, 4'b0100, 3'd0, 4'b1011, 0);
      issue("rr_amt4",    4'b1011, 4'b0100, 3'd4, 4'b1011, 0);
      issue("nonrr_0001", 4'b1111, 4'b0001, 3'd3, 4'b0000, 0);
      issue("nonrr_1100", 4'b1111, 4'b1100, 3'd7, 4'b0000, 0);
      issue("rr_amt3",    4'b0110, 4'b0100, 3'd3, 4'b1100, 3);
      issue("rr_amt7",    4'b1000, 4'b1000, 3'd7, 4'b0001, 3);

      // Intermediate values visible while rotating by 2
      @(negedge clk);
      q = 4'b1001; s = 4'b1000; amt = 3'd2; start = 1'b1;
      sbq.push_back('{"rr_b_amt2", 4'b0110, cyc + 3, 2});
      @(negedge clk);
      start = 1'b0;
      scramble();
      chk("mid0_r", r, 4'b1001);
      chk("mid0_busy", {3'b000, busy}, 4'b0001);
      @(negedge clk);
      chk("mid1_r", r, 4'b1100);
      chk("mid1_busy", {3'b000, busy}, 4'b0001);
      wait_idle("rr_b_amt2");

      // Start reasserted with new operands while busy must be ignored
      @(negedge clk);
      q = 4'b0001; s = 4'b0100; amt = 3'd3; start = 1'b1;
      sbq.push_back('{"ignore_busy", 4'b0010, cyc + 4, 3});
      @(negedge clk);
      q = 4'b1111; amt = 3'd1;
      @(negedge clk);
      start = 1'b0;
      scramble();
      wait_idle("ignore_busy");
      repeat (3) @(negedge clk);

      // Start held high: three back-to-back operations, three done pulses
      @(negedge clk);
      q = 4'b0011; s = 4'b1000; amt = 3'd1; start = 1'b1;
      n0 = cyc;
      sbq.push_back('{"b2b_0", 4'b1001, n0 + 2, 1});
      sbq.push_back('{"b2b_1", 4'b1001, n0 + 5, 1});
      sbq.push_back('{"b2b_2", 4'b1001, n0 + 8, 1});
      repeat (7) @(negedge clk);
      start = 1'b0;
      wait_idle("b2b");

      // Reset asserted mid-rotation aborts at once and produces no done
      @(negedge clk);
      q = 4'b1001; s = 4'b0100; amt = 3'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2;
      Reset = 1'b0;
      #1;
      chk("abort_r", r, 4'b0000);
      chk("abort_busy", {3'b000, busy}, 4'b0000);
      chk("abort_done", {3'b000, done}, 4'b0000);
      @(negedge clk);
      Reset = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_idle_busy", {3'b000, busy}, 4'b0000);

      // Unit works normally after the abort
      issue("post_abort", 4'b1001, 4'b0100, 3'd2, 4'b0110, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
